// File: rtl/tree_pkg.sv
// tree_pkg: shared widths, dispatcher state encoding and a constant clog2 helper
package tree_pkg;
  localparam int DEF_PACKET_WIDTH = 104;
  localparam int DEF_NODE_WIDTH = 40;
  typedef enum logic [1:0] {RUN, DRAIN, GRANT} disp_state_e;
  function automatic int clog2(input int v);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: single-push dual-pop header buffer; ports push/din in, pop count 0-2 in, head0/head1/count out
module dispatch_fifo
  import tree_pkg::*;
#(
  parameter int W = DEF_PACKET_WIDTH,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH),
  localparam int CW = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic [1:0]    pop,
  output logic [W-1:0]  head0,
  output logic [W-1:0]  head1,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[rd_q + AW'(1)];
  assign count = count_q;
endmodule

// File: rtl/tree_lookup_dispatcher.sv
// tree_lookup_dispatcher: buffers headers, issues up to two per cycle into the lookup lanes, quiesces the pipeline for table updates
module tree_lookup_dispatcher
  import tree_pkg::*;
#(
  parameter int PACKET_WIDTH = DEF_PACKET_WIDTH,
  parameter int NODE_WIDTH = DEF_NODE_WIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_INFLIGHT = 32,
  localparam int IW = clog2(MAX_INFLIGHT + 1),
  localparam int CW = clog2(FIFO_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    RSTn,
  input  logic [PACKET_WIDTH-1:0] pkt_in,
  input  logic                    pkt_valid_in,
  output logic                    pkt_ready_out,
  input  logic [NODE_WIDTH-1:0]   root_node,
  output logic [PACKET_WIDTH-1:0] packet_out1,
  output logic [PACKET_WIDTH-1:0] packet_out2,
  output logic                    data_valid_out1,
  output logic                    data_valid_out2,
  output logic [NODE_WIDTH-1:0]   node_out1,
  output logic [NODE_WIDTH-1:0]   node_out2,
  output logic                    matched_out1,
  output logic                    matched_out2,
  input  logic                    ret_valid1,
  input  logic                    ret_valid2,
  input  logic                    upd_req,
  output logic                    upd_gnt,
  input  logic                    upd_done,
  output logic [IW-1:0]           inflight,
  output logic                    err_underflow
);
  disp_state_e state_q, state_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic err_q, err_d, ready_q, ready_d, gnt_q, gnt_d, v1_q, v1_d, v2_q, v2_d, push;
  logic [PACKET_WIDTH-1:0] pkt1_q, pkt1_d, pkt2_q, pkt2_d, head0, head1;
  logic [NODE_WIDTH-1:0] node1_q, node1_d, node2_q, node2_d;
  logic [CW-1:0] count;
  int room, n, sum;
  dispatch_fifo #(.W(PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(RSTn), .push(push), .din(pkt_in), .pop(n[1:0]),
    .head0(head0), .head1(head1), .count(count)
  );
  always_comb begin
    room = MAX_INFLIGHT - int'(inflight_q);
    n = (state_q != RUN) ? 0 : (int'(count) < 2 ? int'(count) : 2);
    if (room < n) n = room;
    push = pkt_valid_in && ready_q;
    ready_d = (int'(count) + int'(push) - n) < FIFO_DEPTH;
    // a return with nothing outstanding is an accounting fault: clamp and flag it
    sum = int'(inflight_q) + n - int'(ret_valid1) - int'(ret_valid2);
    inflight_d = sum < 0 ? '0 : IW'(sum);
    err_d = err_q || sum < 0;
    state_d = state_q == RUN   ? (upd_req ? DRAIN : RUN) :
              state_q == DRAIN ? (!upd_req ? RUN : inflight_d == '0 ? GRANT : DRAIN) :
                                 (upd_done ? RUN : GRANT);
    gnt_d = state_d == GRANT;
    v1_d = n >= 1;
    v2_d = n == 2;
    pkt1_d = v1_d ? head0 : pkt1_q;
    node1_d = v1_d ? root_node : node1_q;
    pkt2_d = v2_d ? head1 : pkt2_q;
    node2_d = v2_d ? root_node : node2_q;
  end
  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      state_q <= RUN;
      inflight_q <= '0;
      err_q <= 1'b0;
      ready_q <= 1'b0;
      gnt_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      pkt1_q <= '0;
      pkt2_q <= '0;
      node1_q <= '0;
      node2_q <= '0;
    end else begin
      state_q <= state_d;
      inflight_q <= inflight_d;
      err_q <= err_d;
      ready_q <= ready_d;
      gnt_q <= gnt_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      pkt1_q <= pkt1_d;
      pkt2_q <= pkt2_d;
      node1_q <= node1_d;
      node2_q <= node2_d;
    end
  assign pkt_ready_out = ready_q;
  assign upd_gnt = gnt_q;
  assign inflight = inflight_q;
  assign err_underflow = err_q;
  assign data_valid_out1 = v1_q;
  assign data_valid_out2 = v2_q;
  assign packet_out1 = pkt1_q;
  assign packet_out2 = pkt2_q;
  assign node_out1 = node1_q;
  assign node_out2 = node2_q;
  assign matched_out1 = 1'b0;
  assign matched_out2 = 1'b0;
endmodule

// File: doc/tree_lookup_dispatcher.md
# tree_lookup_dispatcher

Front-end controller for the dual-lane MBitTree lookup pipeline. Accepts classified-packet headers from a single valid/ready stream, buffers them, and issues up to two per cycle into lane 1 and lane 2 of the root tree level with the configured root node. It also quiesces the pipeline for table updates: it stops issuing, waits for every in-flight lookup to drain, then grants the BRAM update port to the configuration agent.

## Interface
Parameters:
- PACKET_WIDTH, 104, header width
- NODE_WIDTH, 40, node word width
- FIFO_DEPTH, 8, input buffer entries (power of two, ≥2)
- MAX_INFLIGHT, 32, maximum lookups outstanding in the pipeline

Ports:
- clk  in  1  single clock
- RSTn  in  1  asynchronous, active-low reset
- pkt_in  in  PACKET_WIDTH  incoming header
- pkt_valid_in  in  1  pkt_in valid
- pkt_ready_out  out  1  buffer can accept (registered)
- root_node  in  NODE_WIDTH  root node word; quasi-static, changed only while upd_gnt=1
- packet_out1 / packet_out2  out  PACKET_WIDTH  lane headers
- data_valid_out1 / data_valid_out2  out  1  lane valid
- node_out1 / node_out2  out  NODE_WIDTH  lane node (= root_node)
- matched_out1 / matched_out2  out  1  always 0 on issue
- ret_valid1 / ret_valid2  in  1  lookup completed at the pipeline tail, one pulse per packet
- upd_req  in  1  config agent requests the update window (level)
- upd_gnt  out  1  pipeline is empty and the BRAMs are free for writing
- upd_done  in  1  one-cycle pulse that ends the window
- inflight  out  clog2(MAX_INFLIGHT+1)  outstanding lookups
- err_underflow  out  1  sticky error: ret pulse seen with inflight=0

## Operation
- FIFO push on pkt_valid_in && pkt_ready_out. Next-cycle pkt_ready_out = (next count < FIFO_DEPTH).
- States: RUN, DRAIN, GRANT.
- In RUN, the block issues n = min(count, 2, MAX_INFLIGHT−inflight) entries.
  - Oldest entry goes to lane 1, next to lane 2.
  - n=1 uses lane 1 only.
- In DRAIN and GRANT, n=0. Pushes continue until the FIFO is full.
- Issued lanes drive the header, node_out=root_node, matched_out=0, valid=1. Unissued lanes drive valid=0; their data outputs hold the last values.
- inflight_next = inflight + n − ret_valid1 − ret_valid2. On a would-be underflow: clamp to 0 and set err_underflow (cleared only by reset).
- Transitions:
  - RUN→DRAIN when upd_req=1. The issue in that same cycle is still performed.
  - DRAIN→GRANT when inflight_next=0.
  - DRAIN→RUN if upd_req drops before GRANT.
  - GRANT→RUN on upd_done.
- upd_gnt = (state==GRANT), registered.
- Simultaneous push and pop is allowed. A push into an empty FIFO is not issuable in the same cycle.

## Timing
- Reset: all outputs 0, including pkt_ready_out. FIFO empty, state RUN, inflight 0. pkt_ready_out rises on the first clock edge after RSTn deasserts.
- A header accepted at edge t is on the lane outputs after edge t+1, at the earliest.
- Issue throughput: 2 per cycle. Sustained input is 1 per cycle, so the FIFO drains whenever it holds ≥2 entries.
- upd_gnt asserts on the edge after inflight reaches 0 in DRAIN. It deasserts on the edge after upd_done. Issue resumes on the following edge.
- upd_done outside GRANT is ignored. upd_req held across GRANT→RUN re-enters DRAIN one cycle later.
- Reset mid-operation discards buffered packets and in-flight accounting, and drops upd_gnt immediately (asynchronously).

## Structure
- Shared package `tree_pkg`:
  - PACKET_WIDTH / NODE_WIDTH defaults
  - dispatcher state enum {RUN, DRAIN, GRANT}
  - clog2 helper
- Sub-module `dispatch_fifo`: single push, dual pop (pop count 0–2), exposing head0/head1 and count. Pointers wrap modulo FIFO_DEPTH.
- The FSM, inflight counter and lane output registers live in the top module.

## Test plan
- Reset, then push headers A,B,C on consecutive cycles → A on lane 1 one cycle after acceptance, then B and C; inflight increments; outputs carry node_out=root_node, matched=0.
- Stall the consumer: returns held 0 and MAX_INFLIGHT=4, push 8 headers → exactly 4 issued, 4 buffered, inflight=4. Pulse ret_valid1 and ret_valid2 together → inflight=2 in that edge's update, then 2 more issued the next cycle.
- Push 9 headers with issue blocked (DRAIN) → pkt_ready_out drops after the 8th acceptance; the 9th is held by the source.
- With inflight=3, raise upd_req → no further issue. Returns ret_valid1, ret_valid2 and ret_valid1 on three cycles → upd_gnt=1 one edge after inflight=0. Pulse upd_done → upd_gnt=0 next edge, issue resumes the edge after that.
- Raise upd_req, then drop it while inflight=2 → returns to RUN with no upd_gnt pulse.
- Pulse ret_valid2 with inflight=0 → inflight stays 0 and err_underflow=1 until RSTn.
